// File: rtl/drum_mul_arbiter_if.sv
// Bundles the requester-side operand handshakes and the shared result port
// of drum_mul_arbiter so both ends connect through one interface instance.
interface drum_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int N_WIDTH = 16,
    parameter int M_WIDTH = 16,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*N_WIDTH-1:0] req_a;
    logic [NUM_REQ*M_WIDTH-1:0] req_b;
    logic                       res_valid;
    logic                       res_ready;
    logic [N_WIDTH+M_WIDTH-1:0] res_data;
    logic [ID_W-1:0]            res_id;
    logic                       busy;

    // Arbiter side: consumes operands and the result-ready, drives the rest.
    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id, busy
    );

    // Requester/consumer side.
    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/drum_mul_arbiter.sv
// Round-robin arbiter sharing one DRUM approximate multiplier between
// NUM_REQ requesters. Two pipeline stages: operand register (stage 1) and
// result register (stage 2). Results leave in acceptance order, tagged with
// the originating requester index.
module drum_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int N_WIDTH = 16,
    parameter int M_WIDTH = 16,
    parameter int K       = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    drum_mul_arbiter_if.slave   io_bus
);

    localparam int W  = (N_WIDTH > M_WIDTH) ? N_WIDTH : M_WIDTH;
    localparam int SW = $clog2(W) + 1;
    localparam int P  = N_WIDTH + M_WIDTH;

    // Truncated mantissa and its left shift for one DRUM operand.
    typedef struct packed {
        logic [K-1:0]  mant;
        logic [SW-1:0] shift;
    } drum_op_t;

    // Keep the leading one, the K-2 bits below it and force the LSB to 1
    // (unbiasing); small values pass through exactly with no shift.
    function automatic drum_op_t drum_encode(input logic [W-1:0] v);
        drum_op_t r;
        int       t;
        r = '0;
        t = 0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) t = i;
        end
        if (t <= K - 1) begin
            r.mant = v[K-1:0];
        end else begin
            r.mant[K-1] = 1'b1;
            r.mant[0]   = 1'b1;
            for (int j = 1; j <= K - 2; j++) begin
                r.mant[j] = v[t-K+1+j];
            end
            r.shift = SW'(t - K + 1);
        end
        return r;
    endfunction

    // Product of two encoded operands, rescaled by the combined shift.
    function automatic logic [P-1:0] drum_mul(input logic [N_WIDTH-1:0] a,
                                              input logic [M_WIDTH-1:0] b);
        drum_op_t   ea;
        drum_op_t   eb;
        logic [P-1:0] prod;
        ea   = drum_encode(W'(a));
        eb   = drum_encode(W'(b));
        prod = P'(ea.mant) * P'(eb.mant);
        return prod << (ea.shift + eb.shift);
    endfunction

    // Pipeline state.
    logic               r_s1_valid;
    logic [N_WIDTH-1:0] r_s1_a;
    logic [M_WIDTH-1:0] r_s1_b;
    logic [ID_W-1:0]    r_s1_id;
    logic               r_s2_valid;
    logic [P-1:0]       r_s2_data;
    logic [ID_W-1:0]    r_s2_id;
    logic [ID_W-1:0]    r_rr_ptr;

    // Pipeline control and arbitration results.
    logic               w_s2_load;
    logic               w_s1_free;
    logic               w_found;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_hs;
    logic [ID_W-1:0]    w_rr_next;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [N_WIDTH-1:0] w_sel_a;
    logic [M_WIDTH-1:0] w_sel_b;
    logic [P-1:0]       w_product;

    // Stage 2 takes stage 1 whenever it is empty or being drained.
    assign w_s2_load = r_s1_valid & (~r_s2_valid | io_bus.res_ready);
    assign w_s1_free = ~r_s1_valid | w_s2_load;
    assign w_hs      = w_s1_free & w_found;
    assign w_rr_next = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
    assign w_product = drum_mul(r_s1_a, r_s1_b);

    // Round-robin search from r_rr_ptr upward with wrap-around.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        w_found    = 1'b0;
        w_grant_id = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!w_found && io_bus.req_valid[(int'(r_rr_ptr) + off) % NUM_REQ]) begin
                w_found    = 1'b1;
                w_grant_id = ID_W'((int'(r_rr_ptr) + off) % NUM_REQ);
            end
        end
    end

    // One-hot ready to the granted requester and its operand mux.
    always_comb begin
        w_req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_ready[i] = w_hs & (w_grant_id == ID_W'(i));
        end
        w_sel_a = io_bus.req_a[int'(w_grant_id)*N_WIDTH +: N_WIDTH];
        w_sel_b = io_bus.req_b[int'(w_grant_id)*M_WIDTH +: M_WIDTH];
    end

    // Stage 1: capture the granted operand pair; rotate priority past it.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are reset too so the pipeline is fully
        // defined (and res_data reads 0) straight out of reset.
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
            r_rr_ptr   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            if (w_hs) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= w_sel_a;
                r_s1_b     <= w_sel_b;
                r_s1_id    <= w_grant_id;
                r_rr_ptr   <= w_rr_next;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: register the DRUM product; hold it under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_id    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_s2_data  <= w_product;
            r_s2_id    <= r_s1_id;
        end else if (io_bus.res_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign io_bus.req_ready = w_req_ready;
    assign io_bus.res_valid = r_s2_valid;
    assign io_bus.res_data  = r_s2_data;
    assign io_bus.res_id    = r_s2_id;
    assign io_bus.busy      = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_drum_mul_arbiter.sv
// Scoreboard bench for drum_mul_arbiter: stimulus pushes hand-computed
// expected results, a negedge monitor pops and compares every transfer.
module tb_drum_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int NW      = 16;
    localparam int MW      = 16;
    localparam int K       = 4;
    localparam int ID_W    = 2;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    exp_t mon_e;

    drum_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .N_WIDTH(NW), .M_WIDTH(MW), .ID_W(ID_W)) bus ();

    drum_mul_arbiter #(
        .NUM_REQ(NUM_REQ), .N_WIDTH(NW), .M_WIDTH(MW), .K(K), .ID_W(ID_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Present one operand pair and wait (bounded) for its handshake.
    task automatic send(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input bit push);
        bit ok;
        ok = 1'b0;
        if (push) sb.push_back('{id: ID_W'(id), data: exp});
        bus.req_a[id*NW +: NW] = a;
        bus.req_b[id*MW +: MW] = b;
        bus.req_valid[id]      = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
    endtask

    // Wait (bounded) until every expected result has left the DUT.
    task automatic drain();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.res_valid) break;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every accepted result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got id %0d data 0x%0h, required no result",
                         bus.res_id, bus.res_data);
            end else begin
                mon_e = sb.pop_front();
                check("res_id", 32'(bus.res_id), 32'(mon_e.id));
                check("res_data", bus.res_data, mon_e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;

        // Reset and idle
        #1 rst_n = 1'b0;
        #1;
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_res_id", 32'(bus.res_id), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_res_valid", 32'(bus.res_valid), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;

        // Exact small operands with latency check
        send(2, 16'd5, 16'd7, 32'd35, 1'b1);
        @(negedge clk);
        check("req_ready_one_cycle", 32'(bus.req_ready), 32'd0);
        check("lat_early", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        check("lat_res_valid", 32'(bus.res_valid), 32'd1);
        drain();
        @(posedge clk);
        #1;

        // Approximation cases; last handshake on requester 3 leaves rr_ptr=0
        send(1, 16'd1000, 16'd1000, 32'd921600, 1'b1);
        send(0, 16'hFFFF, 16'hFFFF, 32'hE100_0000, 1'b1);
        send(1, 16'd15, 16'd16, 32'd270, 1'b1);
        send(2, 16'h1234, 16'd0, 32'd0, 1'b1);
        send(3, 16'd0, 16'h1234, 32'd0, 1'b1);
        drain();
        @(posedge clk);
        #1;

        // Round robin: all four valid, two rounds, one grant per cycle
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++)
                sb.push_back('{id: ID_W'(i), data: 32'((i + 1) * (r + 2))});
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*NW +: NW] = 16'(i + 1);
            bus.req_b[i*MW +: MW] = 16'd2;
        end
        bus.req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(bus.req_ready), 32'(1 << (k % NUM_REQ)));
            @(posedge clk);
            #1;
            if (k < NUM_REQ) bus.req_b[(k % NUM_REQ)*MW +: MW] = 16'd3;
            else             bus.req_valid[k % NUM_REQ] = 1'b0;
        end
        drain();
        @(posedge clk);
        #1;

        // Backpressure: fill both stages, stall 5 cycles, then release
        bus.res_ready = 1'b0;
        send(0, 16'd3, 16'd3, 32'd9, 1'b1);
        send(1, 16'd100, 16'd3, 32'd312, 1'b1);
        sb.push_back('{id: 2'd2, data: 32'd4});
        bus.req_a[2*NW +: NW] = 16'd2;
        bus.req_b[2*MW +: MW] = 16'd2;
        bus.req_valid[2]      = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
            check("stall_res_valid", 32'(bus.res_valid), 32'd1);
            check("stall_res_data", bus.res_data, 32'd9);
            check("stall_res_id", 32'(bus.res_id), 32'd0);
        end
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        @(negedge clk);
        check("release_req_ready", 32'(bus.req_ready), 32'b0100);
        @(posedge clk);
        #1 bus.req_valid[2] = 1'b0;
        drain();
        @(posedge clk);
        #1;

        // Skip idle requesters: handshake on 0 sets rr_ptr=1
        send(0, 16'd2, 16'd3, 32'd6, 1'b1);
        drain();
        @(posedge clk);
        #1;
        sb.push_back('{id: 2'd3, data: 32'd42});
        sb.push_back('{id: 2'd0, data: 32'd15});
        bus.req_a[3*NW +: NW] = 16'd6;
        bus.req_b[3*MW +: MW] = 16'd7;
        bus.req_a[0*NW +: NW] = 16'd3;
        bus.req_b[0*MW +: MW] = 16'd5;
        bus.req_valid = 4'b1001;
        @(negedge clk);
        check("skip_first", 32'(bus.req_ready), 32'b1000);
        @(posedge clk);
        #1 bus.req_valid[3] = 1'b0;
        @(negedge clk);
        check("skip_second", 32'(bus.req_ready), 32'b0001);
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        drain();
        @(posedge clk);
        #1;

        // Reset while both stages are full: everything in flight is dropped
        bus.res_ready = 1'b0;
        send(1, 16'd7, 16'd7, 32'd49, 1'b0);
        send(2, 16'd9, 16'd9, 32'd81, 1'b0);
        @(negedge clk);
        check("full_busy", 32'(bus.busy), 32'd1);
        check("full_res_valid", 32'(bus.res_valid), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_res_data", bus.res_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.res_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/drum_mul_arbiter.md
Name: drum_mul_arbiter

Overview:
Shares one combinational DRUM approximate multiplier (K-bit dynamic-range truncation, unbiased) among NUM_REQ requesters using round-robin arbitration. Operand pairs are accepted with per-requester valid/ready handshakes and pass through a 2-stage pipeline: an operand register, then the multiplier feeding a result register. Each result leaves on one shared output with the originating requester index and backpressure. The block sits between accelerator lanes and the single multiplier instance.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
N_WIDTH, 16, operand A width
M_WIDTH, 16, operand B width
K, 4, DRUM truncation width passed to multiplier core (3 <= K <= min(N_WIDTH,M_WIDTH))
ID_W, $clog2(NUM_REQ), requester index width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept; at most one bit high
req_a  input  NUM_REQ*N_WIDTH  packed A operands, requester i at [i*N_WIDTH +: N_WIDTH]
req_b  input  NUM_REQ*M_WIDTH  packed B operands, same packing
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_data  output  N_WIDTH+M_WIDTH  DRUM product
res_id  output  ID_W  index of originating requester
busy  output  1  high when either pipeline stage holds data

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, rr_ptr=0. Outputs: res_valid=0, res_data=0, res_id=0, busy=0, req_ready=0. Data registers clear to 0.
- Reset asserted mid-operation discards all in-flight operations. No result is produced for them.
- Stage 2 (result register) holds res_data, res_id and s2_valid. It drives the outputs directly.
- s2_load = s1_valid & (!s2_valid | res_ready).
- s1_adv = s2_load. s1_free = !s1_valid | s1_adv.
- Arbitration is combinational. The grant goes to the first i with req_valid[i], searching from rr_ptr upward with wrap-around. The grant is issued only when s1_free=1.
- req_ready[i] = s1_free & grant[i]. A handshake on requester i loads a/b/id into stage 1 (s1_valid=1).
- On a handshake, rr_ptr <= (i+1) mod NUM_REQ. With no handshake, rr_ptr holds.
- req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- On s2_load, stage 2 captures DRUM(s1_a, s1_b) and s1_id.
- If s1_valid=0 and res_ready=1, s2_valid clears. Otherwise stage 2 holds its value while res_valid & !res_ready.
- DRUM arithmetic, with t = index of the leading one:
  - t <= K-1: use the low K bits exactly, shift 0.
  - Otherwise: operand = {1, bits[t-1 -: K-2], 1}, shift t-K+1.
  - Product = (opA*opB) << (shiftA+shiftB), zero-extended to N_WIDTH+M_WIDTH.
  - A zero operand gives 0.
- Latency: handshake on edge T gives res_valid=1 after edge T+1, with no stall.
- Throughput: 1 result per cycle while res_ready=1.
- Full-stall: when both stages are valid and res_ready=0, req_ready is all-zero. Nothing is lost or duplicated.
- Stall release: res_ready=1 with both stages full moves stage1 to stage2 and accepts a new request in the same cycle.
- Order: results leave strictly in acceptance order.
- busy = s1_valid | s2_valid.

Test Plan:
- Reset/idle: hold rst_n=0, then release with no requests. Required: all outputs 0, busy=0. Assert rst_n low while both stages are full. Required: res_valid drops immediately with no clock, and no result appears afterwards.
- Exact small operands: requester 2 sends a=5, b=7, res_ready=1. Required: req_ready[2] high for one cycle; 2 cycles later res_data=35, res_id=2.
- Approximation: a=1000, b=1000 gives res_data=921600. a=0xFFFF, b=0xFFFF gives res_data=0xE1000000. a=0 with any b gives 0.
- Round-robin fairness: all four requesters valid continuously, res_ready=1. Required grant order 0,1,2,3,0,1…, one result per cycle, res_id sequence matching.
- Backpressure: two requests accepted, then res_ready=0 for 5 cycles. Required:
  - res_valid stays high and res_data/res_id stay stable.
  - req_ready is all-zero after stage 1 fills.
  - On res_ready=1, both results drain in order with no loss or duplicate.
- Skip idle requesters: rr_ptr=1 with only req_valid[0] and req_valid[3] high. Required: grant 3 first, then 0.
